tt_um_not_arbiter: RTL and testbench

TT_UM_NOT_ARBITER -- requirements
Module: tt_um_not_arbiter

---
 rtl/tt_um_not_arbiter.sv | 74 +++++++
 tb/tb_tt_um_not_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/tt_um_not_arbiter.sv
// tt_um_not_arbiter: four requesters share one registered inverter through a round-robin IDLE/HOLD/RELEASE handshake; define NOT_ARB_STATS_EN to expose a completed-transaction counter on uio_out.
module tt_um_not_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_t;
  state_t state_q, state_d;
  logic [3:0] req, data, grant_q, grant_d;
  logic result_q, result_d, valid_q, valid_d, ack, start, done, unused;
  logic [1:0] idx_q, idx_d, ptr_q, ptr_d, pick;
  assign req = ui_in[3:0];
  assign data = ui_in[7:4];
  assign ack = uio_in[0];
  assign unused = &{1'b0, ena, uio_in[7:1]};
  assign start = state_q == IDLE && |req;
  assign done = state_q == HOLD && (ack || !req[idx_q]);
  // round-robin search from ptr+1 up to ptr itself; the nearest pending requester wins
  always_comb begin
    pick = ptr_q;
    for (int i = 4; i >= 1; i--) pick = req[ptr_q + 2'(i)] ? ptr_q + 2'(i) : pick;
  end
  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      result_q <= 1'b0;
      valid_q <= 1'b0;
      idx_q <= '0;
      ptr_q <= 2'd3;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      result_q <= result_d;
      valid_q <= valid_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
    end
  end
  // next state: grant from IDLE, leave HOLD on ack or abort, RELEASE lasts one cycle
  always_comb state_d = state_q == IDLE ? (|req ? HOLD : IDLE) : state_q == HOLD ? (done ? RELEASE : HOLD) : IDLE;
  // outputs are captured at grant, frozen through HOLD, and cleared on leaving HOLD
  always_comb begin
    grant_d = start ? 4'b0001 << pick : done ? 4'b0000 : grant_q;
    result_d = start ? ~data[pick] : done ? 1'b0 : result_q;
    valid_d = start ? 1'b1 : done ? 1'b0 : valid_q;
    idx_d = start ? pick : done ? 2'd0 : idx_q;
    ptr_d = start ? pick : ptr_q;
  end
  assign uo_out = {idx_q, valid_q, result_q, grant_q};
`ifdef NOT_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // only ack-completed transactions count; aborts and resets do not
  always_comb cnt_d = (state_q == HOLD && ack) ? cnt_q + 1'b1 : cnt_q;
  // transaction counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign uio_out = 8'(cnt_q);
  assign uio_oe = 8'hFF;
`else
  assign uio_out = 8'h00;
  assign uio_oe = 8'h00;
`endif
endmodule

// File: tb/tb_tt_um_not_arbiter.sv
// tb_tt_um_not_arbiter: randomized and directed scoreboard bench for tt_um_not_arbiter.
module tb_tt_um_not_arbiter;
  localparam int CNT_W = 8;
`ifdef NOT_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic [7:0] ui_in = 8'h00, uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  int tests = 0, fails = 0;
  logic [7:0] exp_q[$];
  int mph = 0, mptr = 3, midx = 0, mcnt = 0;
  logic [7:0] cur = 8'h00;
  logic pv = 1'b0;

  tt_um_not_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] cnt_exp(input int n);
    return STATS ? 8'(n % (1 << CNT_W)) : 8'h00;
  endfunction

  // reference model: transaction-level view of the arbitration rules
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mph = 0; mptr = 3; midx = 0; mcnt = 0;
      exp_q.delete();
    end else if (mph == 0) begin
      if (ui_in[3:0] != 4'h0) begin
        for (int k = 1; k <= 4; k++)
          if (ui_in[(mptr + k) % 4]) begin midx = (mptr + k) % 4; break; end
        mptr = midx;
        exp_q.push_back({2'(midx), 1'b1, ~ui_in[4 + midx], 4'(1 << midx)});
        mph = 1;
      end
    end else if (mph == 1) begin
      if (uio_in[0]) begin mcnt = (mcnt + 1) % (1 << CNT_W); mph = 2; end
      else if (!ui_in[midx]) mph = 2;
    end else mph = 0;
  end

  // monitor: pop an expectation when valid rises, then hold it for the whole grant
  always @(negedge clk) begin
    if (!rst_n) pv = 1'b0;
    else begin
      if (uo_out[5] && !pv) begin
        if (exp_q.size() == 0) chk("unexpected_grant", uo_out, 8'h00);
        else cur = exp_q.pop_front();
      end
      chk("valid", {7'b0, uo_out[5]}, {7'b0, mph == 1});
      if (uo_out[5]) chk("grant_word", uo_out, cur);
      else chk("idle_outputs", uo_out & 8'hEF, 8'h00);
      chk("uio_out", uio_out, cnt_exp(mcnt));
      chk("uio_oe", uio_oe, STATS ? 8'hFF : 8'h00);
      pv = uo_out[5];
    end
  end

  task automatic drive(input logic [7:0] ui, input logic ack);
    ui_in = ui;
    uio_in = {7'b0, ack};
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("reset_uo_out", uo_out, 8'h00);
    chk("reset_uio_out", uio_out, 8'h00);
    do_reset();
    // single grant, requester 0 with data 0
    drive(8'h01, 1'b0);
    chk("first_grant", uo_out, 8'h31);
    drive(8'h01, 1'b1);
    drive(8'h00, 1'b0);
    // all requesting: order 0,1,2,3,0 with RELEASE between
    do_reset();
    for (int t = 0; t < 5; t++) begin
      drive(8'h0F, 1'b0);
      chk("rr_order", {6'b0, uo_out[7:6]}, 8'(t % 4));
      drive(8'h0F, 1'b1);
      chk("release_gap", uo_out & 8'hEF, 8'h00);
      drive(8'h0F, 1'b0);
    end
    chk("count_5", uio_out, cnt_exp(5));
    // data toggling during HOLD must not move result
    do_reset();
    drive(8'h44, 1'b0);
    chk("grant2", uo_out, 8'hA4);
    drive(8'h04, 1'b0);
    chk("hold_data0", uo_out, 8'hA4);
    drive(8'h44, 1'b0);
    chk("hold_data1", uo_out, 8'hA4);
    drive(8'h04, 1'b1);
    chk("ack_clears", {7'b0, uo_out[5]}, 8'h00);
    drive(8'h00, 1'b0);
    // abort vs ack-wins
    drive(8'h04, 1'b0);
    drive(8'h00, 1'b0);
    chk("abort_valid", {7'b0, uo_out[5]}, 8'h00);
    chk("abort_count", uio_out, cnt_exp(1));
    drive(8'h00, 1'b0);
    drive(8'h04, 1'b0);
    drive(8'h00, 1'b1);
    chk("ack_wins_count", uio_out, cnt_exp(2));
    drive(8'h00, 1'b0);
    for (int t = 0; t < 5; t++) begin
      drive(8'h01, 1'b0);
      drive(8'h01, 1'b1);
      drive(8'h00, 1'b0);
    end
    chk("count_7", uio_out, cnt_exp(7));
    // asynchronous reset in the middle of HOLD
    drive(8'h01, 1'b0);
    chk("pre_reset_valid", {7'b0, uo_out[5]}, 8'h01);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_uo_out", uo_out, 8'h00);
    chk("async_rst_uio_out", uio_out, 8'h00);
    do_reset();
    // 256 completions wrap the counter
    for (int t = 0; t < 256; t++) begin
      drive(8'h0F, 1'b0);
      drive(8'h0F, 1'b1);
      drive(8'h0F, 1'b0);
    end
    chk("wrap_256", uio_out, 8'h00);
    // random traffic against the model
    do_reset();
    for (int t = 0; t < 2000; t++)
      drive(8'($urandom), $urandom_range(0, 3) == 0);
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b0);
    chk("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
